// File: rtl/arm_isa_pkg.sv
// ARM7 instruction-set constants shared by the issue-stage decode and scoreboard.
package arm_isa_pkg;

  typedef enum logic [3:0] {
    CLS_ALU,
    CLS_MUL,
    CLS_MULL,
    CLS_SWP,
    CLS_BX,
    CLS_XFER,
    CLS_HXFER,
    CLS_BLOCK,
    CLS_BRANCH,
    CLS_COP,
    CLS_UNDEF
  } insn_class_e;

  localparam logic [3:0] OP_TST  = 4'b1000;
  localparam logic [3:0] OP_TEQ  = 4'b1001;
  localparam logic [3:0] OP_CMP  = 4'b1010;
  localparam logic [3:0] OP_CMN  = 4'b1011;
  localparam logic [3:0] OP_MOV  = 4'b1101;
  localparam logic [3:0] OP_MVN  = 4'b1111;
  localparam logic [3:0] COND_AL = 4'b1110;

  localparam int COND_LSB = 28;
  localparam int OPC_LSB  = 21;
  localparam int RN_LSB   = 16;
  localparam int RD_LSB   = 12;
  localparam int RS_LSB   = 8;
  localparam int RM_LSB   = 0;
  localparam int BIT_I    = 25;
  localparam int BIT_P    = 24;
  localparam int BIT_LINK = 24;
  localparam int BIT_HIMM = 22;
  localparam int BIT_A    = 21;
  localparam int BIT_W    = 21;
  localparam int BIT_S    = 20;
  localparam int BIT_L    = 20;
  localparam int BIT_SH   = 4;

  function automatic logic [15:0] reg_bit(input logic [3:0] r);
    return 16'h0001 << r;
  endfunction

endpackage

// File: rtl/arm_reg_decode.sv
// Combinational register-usage decode: which registers an instruction reads and writes,
// and whether it touches the flags or must run against an empty scoreboard.
module arm_reg_decode
  import arm_isa_pkg::*;
#(
  parameter int SERIALIZE_COP = 1
) (
  input  logic [31:0] insn_i,
  output logic [15:0] src_o,
  output logic [15:0] dst_o,
  output logic        rdflags_o,
  output logic        wrflags_o,
  output logic        serialize_o
);

  insn_class_e cls;
  logic [15:0] rn_m, rd_m, rs_m, rm_m, src;
  logic [3:0]  opc;

  assign rn_m = reg_bit(insn_i[RN_LSB +: 4]);
  assign rd_m = reg_bit(insn_i[RD_LSB +: 4]);
  assign rs_m = reg_bit(insn_i[RS_LSB +: 4]);
  assign rm_m = reg_bit(insn_i[RM_LSB +: 4]);
  assign opc  = insn_i[OPC_LSB +: 4];

  // Multiply and swap live inside the ALU encoding space, so they must be matched first.
  always_comb begin
    cls = CLS_COP;
    if (insn_i[27:22] == 6'b000000 && insn_i[7:4] == 4'b1001)
      cls = CLS_MUL;
    else if (insn_i[27:23] == 5'b00001 && insn_i[7:4] == 4'b1001)
      cls = CLS_MULL;
    else if (insn_i[27:23] == 5'b00010 && insn_i[21:20] == 2'b00 && insn_i[11:4] == 8'h09)
      cls = CLS_SWP;
    else if (insn_i[27:4] == 24'h12FFF1)
      cls = CLS_BX;
    else if (insn_i[27:25] == 3'b000 && insn_i[7] && insn_i[4] && insn_i[6:5] != 2'b00)
      cls = CLS_HXFER;
    else if (insn_i[27:26] == 2'b00)
      cls = CLS_ALU;
    else if (insn_i[27:26] == 2'b01)
      cls = (insn_i[BIT_I] && insn_i[BIT_SH]) ? CLS_UNDEF : CLS_XFER;
    else if (insn_i[27:25] == 3'b100)
      cls = CLS_BLOCK;
    else if (insn_i[27:25] == 3'b101)
      cls = CLS_BRANCH;
  end

  always_comb begin
    src         = '0;
    dst_o       = '0;
    wrflags_o   = 1'b0;
    serialize_o = 1'b0;
    rdflags_o   = insn_i[COND_LSB +: 4] != COND_AL;
    case (cls)
      CLS_ALU: begin
        if (opc != OP_MOV && opc != OP_MVN) src = src | rn_m;
        if (!insn_i[BIT_I]) begin
          src = src | rm_m;
          if (insn_i[BIT_SH]) src = src | rs_m;
        end
        if (!(opc == OP_TST || opc == OP_TEQ || opc == OP_CMP || opc == OP_CMN)) dst_o = rd_m;
        wrflags_o = insn_i[BIT_S];
      end
      CLS_MUL: begin
        src       = rm_m | rs_m | (insn_i[BIT_A] ? rd_m : 16'h0000);
        dst_o     = rn_m;
        wrflags_o = insn_i[BIT_S];
      end
      CLS_MULL: begin
        src       = rm_m | rs_m | (insn_i[BIT_A] ? (rn_m | rd_m) : 16'h0000);
        dst_o     = rn_m | rd_m;
        wrflags_o = insn_i[BIT_S];
      end
      CLS_SWP: begin
        src   = rn_m | rm_m;
        dst_o = rd_m;
      end
      CLS_BX: begin
        src   = rm_m;
        dst_o = 16'h8000;
      end
      CLS_XFER, CLS_HXFER: begin
        src = rn_m;
        if ((cls == CLS_XFER && insn_i[BIT_I]) || (cls == CLS_HXFER && !insn_i[BIT_HIMM]))
          src = src | rm_m;
        if (insn_i[BIT_L]) dst_o = rd_m;
        else               src   = src | rd_m;
        if (insn_i[BIT_W] || !insn_i[BIT_P]) dst_o = dst_o | rn_m;
      end
      CLS_BLOCK: begin
        src = rn_m | (insn_i[BIT_L] ? 16'h0000 : insn_i[15:0]);
        dst_o = (insn_i[BIT_L] ? insn_i[15:0] : 16'h0000) | (insn_i[BIT_W] ? rn_m : 16'h0000);
      end
      CLS_BRANCH: dst_o = insn_i[BIT_LINK] ? 16'hC000 : 16'h8000;
      default:    serialize_o = SERIALIZE_COP != 0;
    endcase
  end

  // PC reads never hazard: the pipeline always supplies the current pc.
  assign src_o = src & 16'h7FFF;

endmodule

// File: rtl/issue_scoreboard.sv
// Issue-stage hazard controller: holds instructions until their operands and flags have
// no outstanding writebacks, and counts in-flight writes per register and for the CPSR.
module issue_scoreboard
  import arm_isa_pkg::*;
#(
  parameter int CNT_W         = 2,
  parameter int SERIALIZE_COP = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        inbubble,
  input  logic [31:0] insn,
  input  logic [31:0] inpc,
  input  logic        retire_valid,
  input  logic [15:0] retire_regs,
  input  logic        retire_cpsr,
  output logic        outbubble,
  output logic [31:0] outpc,
  output logic [31:0] outinsn,
  output logic [15:0] outdst,
  output logic        outcpsr,
  output logic        hazard
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [15:0]      src, dst;
  logic             rdflags, wrflags, serialize;
  logic [CNT_W-1:0] cnt_q [16];
  logic [CNT_W-1:0] cnt_d [16];
  logic [CNT_W-1:0] cpsr_q, cpsr_d;
  logic [15:0]      nz, sat;
  logic             cpsr_nz, cpsr_sat, issue;
  logic             outbubble_q, outcpsr_q;
  logic [31:0]      outpc_q, outinsn_q;
  logic [15:0]      outdst_q;

  arm_reg_decode #(.SERIALIZE_COP(SERIALIZE_COP)) u_dec (
    .insn_i      (insn),
    .src_o       (src),
    .dst_o       (dst),
    .rdflags_o   (rdflags),
    .wrflags_o   (wrflags),
    .serialize_o (serialize)
  );

  always_comb begin
    for (int r = 0; r < 16; r++) begin
      nz[r]  = cnt_q[r] != '0;
      sat[r] = cnt_q[r] == CNT_MAX;
    end
    cpsr_nz  = cpsr_q != '0;
    cpsr_sat = cpsr_q == CNT_MAX;
  end

  // A saturated destination counter blocks issue so the count can never wrap.
  assign hazard = !inbubble && !flush &&
                  ((|(src & nz)) || (rdflags && cpsr_nz) || (|(dst & sat)) ||
                   (wrflags && cpsr_sat) || (serialize && ((|nz) || cpsr_nz)));
  assign issue  = !stall && !inbubble && !flush && !hazard;

  // Retire of a zero counter is ignored so a protocol slip cannot underflow it.
  always_comb begin
    for (int r = 0; r < 16; r++) begin
      cnt_d[r] = cnt_q[r];
      case ({issue && dst[r], retire_valid && retire_regs[r] && nz[r]})
        2'b10:   cnt_d[r] = cnt_q[r] + CNT_ONE;
        2'b01:   cnt_d[r] = cnt_q[r] - CNT_ONE;
        default: cnt_d[r] = cnt_q[r];
      endcase
    end
    case ({issue && wrflags, retire_valid && retire_cpsr && cpsr_nz})
      2'b10:   cpsr_d = cpsr_q + CNT_ONE;
      2'b01:   cpsr_d = cpsr_q - CNT_ONE;
      default: cpsr_d = cpsr_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 16; r++) cnt_q[r] <= '0;
      cpsr_q <= '0;
    end else begin
      for (int r = 0; r < 16; r++) begin
        if (retire_valid && retire_regs[r]) assert (nz[r]);
        cnt_q[r] <= cnt_d[r];
      end
      if (retire_valid && retire_cpsr) assert (cpsr_nz);
      cpsr_q <= cpsr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outbubble_q <= 1'b1;
      outpc_q     <= '0;
      outinsn_q   <= '0;
      outdst_q    <= '0;
      outcpsr_q   <= 1'b0;
    end else if (!stall) begin
      if (issue) begin
        outbubble_q <= 1'b0;
        outpc_q     <= inpc;
        outinsn_q   <= insn;
        outdst_q    <= dst;
        outcpsr_q   <= wrflags;
      end else begin
        outbubble_q <= 1'b1;
        outdst_q    <= '0;
        outcpsr_q   <= 1'b0;
      end
    end
  end

  assign outbubble = outbubble_q;
  assign outpc     = outpc_q;
  assign outinsn   = outinsn_q;
  assign outdst    = outdst_q;
  assign outcpsr   = outcpsr_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Bench for issue_scoreboard: directed hazard scenarios, then randomized traffic against a
// per-register outstanding-write model.
module tb_issue_scoreboard;

  localparam int MAXC = 3;

  typedef struct packed {
    logic [31:0] insn;
    logic [15:0] src;
    logic [15:0] dst;
    logic        rdf;
    logic        wrf;
    logic        ser;
  } ins_t;

  typedef struct packed {
    logic [15:0] d;
    logic        c;
  } ent_t;

  logic        clk = 1'b0, rst = 1'b0, stall = 1'b0, flush = 1'b0, inbubble = 1'b1;
  logic        retire_valid = 1'b0, retire_cpsr = 1'b0;
  logic [31:0] insn = '0, inpc = '0;
  logic [15:0] retire_regs = '0;
  logic        outbubble, outcpsr, hazard;
  logic [31:0] outpc, outinsn;
  logic [15:0] outdst;

  always #5 clk = ~clk;

  issue_scoreboard #(.CNT_W(2), .SERIALIZE_COP(1)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .inbubble(inbubble),
    .insn(insn), .inpc(inpc), .retire_valid(retire_valid), .retire_regs(retire_regs),
    .retire_cpsr(retire_cpsr), .outbubble(outbubble), .outpc(outpc), .outinsn(outinsn),
    .outdst(outdst), .outcpsr(outcpsr), .hazard(hazard)
  );

  int          total = 0, bad = 0;
  int          cnt [16];
  int          ccnt = 0;
  ent_t        q[$];
  logic        m_ob = 1'b1, m_cpsr = 1'b0, haz_seen = 1'b0;
  logic [31:0] m_pc = '0, m_insn = '0, pcv = 32'h100;
  logic [15:0] m_dst = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic ins_t mk(logic [31:0] i, logic [15:0] s, logic [15:0] d,
                              logic rf, logic wf, logic se);
    ins_t x;
    x.insn = i; x.src = s & 16'h7FFF; x.dst = d; x.rdf = rf; x.wrf = wf; x.ser = se;
    return x;
  endfunction

  function automatic logic [15:0] b(logic [3:0] r);
    return 16'h0001 << r;
  endfunction

  function automatic logic [31:0] f(logic [3:0] r, int lsb);
    return 32'(r) << lsb;
  endfunction

  // Random instruction from a family of assembler forms, with its register usage stated per form.
  function automatic ins_t rnd_ins();
    int          k   = $urandom_range(0, 14);
    logic [3:0]  rd  = 4'($urandom), rn = 4'($urandom), rm = 4'($urandom), rs = 4'($urandom);
    logic        s   = 1'($urandom), a = 1'($urandom), w = 1'($urandom), l = 1'($urandom);
    logic [3:0]  c   = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'hE;
    logic [7:0]  im  = 8'($urandom);
    logic [15:0] lst = 16'($urandom);
    logic [31:0] cw  = {c, 28'h0};
    logic [31:0] sb  = {11'h0, s, 20'h0};
    logic        rf  = (c != 4'hE);
    case (k)
      0:  return mk(cw | 32'h00800000 | sb | f(rn,16) | f(rd,12) | f(rm,0), b(rn) | b(rm), b(rd), rf, s, 0);
      1:  return mk(cw | 32'h03A00000 | sb | f(rd,12) | 32'(im), 16'h0, b(rd), rf, s, 0);
      2:  return mk(cw | 32'h03500000 | f(rn,16) | 32'(im), b(rn), 16'h0, rf, 1, 0);
      3:  return mk(cw | 32'h00800010 | sb | f(rn,16) | f(rd,12) | f(rs,8) | f(rm,0),
                    b(rn) | b(rm) | b(rs), b(rd), rf, s, 0);
      4:  return mk(cw | 32'h00000090 | {10'h0, a, 21'h0} | sb | f(rd,16) | f(rn,12) | f(rs,8) | f(rm,0),
                    b(rm) | b(rs) | (a ? b(rn) : 16'h0), b(rd), rf, s, 0);
      5:  return mk(cw | 32'h00800090 | {10'h0, a, 21'h0} | sb | f(rd,16) | f(rn,12) | f(rs,8) | f(rm,0),
                    b(rm) | b(rs) | (a ? (b(rd) | b(rn)) : 16'h0), b(rd) | b(rn), rf, s, 0);
      6:  return mk(cw | 32'h01000090 | f(rn,16) | f(rd,12) | f(rm,0), b(rn) | b(rm), b(rd), rf, 0, 0);
      7:  return mk(cw | 32'h012FFF10 | f(rm,0), b(rm), 16'h8000, rf, 0, 0);
      8:  return mk(cw | 32'h05900000 | {10'h0, w, 21'h0} | f(rn,16) | f(rd,12) | 32'(im),
                    b(rn), b(rd) | (w ? b(rn) : 16'h0), rf, 0, 0);
      9:  return mk(cw | 32'h04800000 | f(rn,16) | f(rd,12) | 32'(im), b(rn) | b(rd), b(rn), rf, 0, 0);
      10: return mk(cw | 32'h07900000 | f(rn,16) | f(rd,12) | f(rm,0), b(rn) | b(rm), b(rd), rf, 0, 0);
      11: if (l) return mk(cw | 32'h019000B0 | f(rn,16) | f(rd,12) | f(rm,0), b(rn) | b(rm), b(rd), rf, 0, 0);
          else   return mk(cw | 32'h01C000B0 | f(rn,16) | f(rd,12) | 32'(im[3:0]), b(rn) | b(rd), 16'h0, rf, 0, 0);
      12: return mk(cw | 32'h08800000 | {10'h0, w, l, 20'h0} | f(rn,16) | 32'(lst),
                    b(rn) | (l ? 16'h0 : lst), (l ? lst : 16'h0) | (w ? b(rn) : 16'h0), rf, 0, 0);
      13: return mk(cw | 32'h0A000000 | {7'h0, l, 24'h0} | 32'(im), 16'h0, l ? 16'hC000 : 16'h8000, rf, 0, 0);
      default: begin
        case ($urandom_range(0, 2))
          0:       return mk(cw | 32'h0E070F10, 16'h0, 16'h0, rf, 0, 1);
          1:       return mk(cw | 32'h0F000000 | 32'(im), 16'h0, 16'h0, rf, 0, 1);
          default: return mk(cw | 32'h07F000F0, 16'h0, 16'h0, rf, 0, 1);
        endcase
      end
    endcase
  endfunction

  function automatic logic model_haz(ins_t x, logic bub, logic fl);
    int busy = ccnt;
    if (bub || fl) return 1'b0;
    for (int r = 0; r < 16; r++) begin
      busy += cnt[r];
      if (x.src[r] && cnt[r] > 0)     return 1'b1;
      if (x.dst[r] && cnt[r] == MAXC) return 1'b1;
    end
    if (x.rdf && ccnt > 0)     return 1'b1;
    if (x.wrf && ccnt == MAXC) return 1'b1;
    return x.ser && busy > 0;
  endfunction

  task automatic model_step(ins_t x, logic bub, logic stl, logic fl, logic rv,
                            logic [15:0] rr, logic rc, logic mh);
    logic iss;
    if (rst) begin
      for (int r = 0; r < 16; r++) cnt[r] = 0;
      ccnt = 0; q.delete();
      m_ob = 1'b1; m_pc = '0; m_insn = '0; m_dst = '0; m_cpsr = 1'b0;
      return;
    end
    iss = !bub && !fl && !mh && !stl;
    for (int r = 0; r < 16; r++) begin
      cnt[r] = cnt[r] + ((iss && x.dst[r]) ? 1 : 0) - ((rv && rr[r]) ? 1 : 0);
      if (cnt[r] < 0) cnt[r] = 0;
    end
    ccnt = ccnt + ((iss && x.wrf) ? 1 : 0) - ((rv && rc) ? 1 : 0);
    if (ccnt < 0) ccnt = 0;
    if (!stl) begin
      if (iss) begin
        m_ob = 1'b0; m_pc = pcv; m_insn = x.insn; m_dst = x.dst; m_cpsr = x.wrf;
        q.push_back({x.dst, x.wrf});
      end else begin
        m_ob = 1'b1; m_dst = '0; m_cpsr = 1'b0;
      end
    end
  endtask

  // One clock: drive at the falling edge, check hazard, let the rising edge act, check outputs.
  task automatic cyc(ins_t x, logic bub, logic stl, logic fl, logic rv, logic [15:0] rr, logic rc);
    logic mh;
    inbubble = bub; insn = x.insn; inpc = pcv; stall = stl; flush = fl;
    retire_valid = rv; retire_regs = rr; retire_cpsr = rc;
    #1;
    mh = model_haz(x, bub, fl);
    chk("hazard", 32'(hazard), 32'(mh));
    haz_seen = hazard;
    model_step(x, bub, stl, fl, rv, rr, rc, mh);
    @(negedge clk);
    chk("outbubble", 32'(outbubble), 32'(m_ob));
    chk("outdst", 32'(outdst), 32'(m_dst));
    chk("outcpsr", 32'(outcpsr), 32'(m_cpsr));
    chk("outpc", outpc, m_pc);
    chk("outinsn", outinsn, m_insn);
    pcv += 4;
  endtask

  task automatic run(ins_t x);
    cyc(x, 0, 0, 0, 0, 16'h0, 0);
  endtask

  task automatic ret(logic [15:0] rr, logic rc);
    cyc('0, 1, 0, 0, 1, rr, rc);
  endtask

  task automatic lit(string nm, logic [31:0] act, logic [31:0] exp);
    chk(nm, act, exp);
  endtask

  ins_t add123, sub41, cmp0, beq, bal, mov5, ldm, add312, mov6, add06, mov7, mov8, add98, mov1, mcr;
  ins_t cur;
  logic hold;

  initial begin
    for (int r = 0; r < 16; r++) cnt[r] = 0;
    add123 = mk(32'hE0821003, 16'h000C, 16'h0002, 0, 0, 0);
    sub41  = mk(32'hE2414001, 16'h0002, 16'h0010, 0, 0, 0);
    cmp0   = mk(32'hE3500000, 16'h0001, 16'h0000, 0, 1, 0);
    beq    = mk(32'h0A000004, 16'h0000, 16'h8000, 1, 0, 0);
    bal    = mk(32'hEA000004, 16'h0000, 16'h8000, 0, 0, 0);
    mov5   = mk(32'hE3A05001, 16'h0000, 16'h0020, 0, 0, 0);
    ldm    = mk(32'hE8B08006, 16'h0001, 16'h8007, 0, 0, 0);
    add312 = mk(32'hE0813002, 16'h0006, 16'h0008, 0, 0, 0);
    mov6   = mk(32'hE3A06001, 16'h0000, 16'h0040, 0, 0, 0);
    add06  = mk(32'hE2860000, 16'h0040, 16'h0001, 0, 0, 0);
    mov7   = mk(32'hE3A07001, 16'h0000, 16'h0080, 0, 0, 0);
    mov8   = mk(32'hE3A08001, 16'h0000, 16'h0100, 0, 0, 0);
    add98  = mk(32'hE2889000, 16'h0100, 16'h0200, 0, 0, 0);
    mov1   = mk(32'hE3A01001, 16'h0000, 16'h0002, 0, 0, 0);
    mcr    = mk(32'hEE070F10, 16'h0000, 16'h0000, 0, 0, 1);

    @(negedge clk);
    rst = 1'b1; cyc('0, 1, 0, 0, 0, 16'h0, 0); rst = 1'b0;
    lit("rst_outbubble", 32'(outbubble), 32'd1);
    lit("rst_outdst", 32'(outdst), 32'd0);
    lit("rst_outpc", outpc, 32'd0);
    lit("rst_outinsn", outinsn, 32'd0);
    lit("rst_outcpsr", 32'(outcpsr), 32'd0);

    // Read-after-write on r1
    run(add123);
    lit("raw_first_dst", 32'(outdst), 32'h0002);
    for (int i = 0; i < 3; i++) begin
      run(sub41);
      lit("raw_hold_haz", 32'(haz_seen), 32'd1);
      lit("raw_hold_bub", 32'(outbubble), 32'd1);
    end
    cyc(sub41, 0, 0, 0, 1, 16'h0002, 0);
    lit("raw_retire_haz", 32'(haz_seen), 32'd1);
    lit("raw_retire_bub", 32'(outbubble), 32'd1);
    run(sub41);
    lit("raw_issue_bub", 32'(outbubble), 32'd0);
    lit("raw_issue_dst", 32'(outdst), 32'h0010);
    ret(16'h0010, 0);

    // Flags
    run(cmp0);
    lit("cmp_cpsr", 32'(outcpsr), 32'd1);
    lit("cmp_dst", 32'(outdst), 32'd0);
    run(beq);
    lit("beq_haz", 32'(haz_seen), 32'd1);
    run(bal);
    lit("bal_haz", 32'(haz_seen), 32'd0);
    lit("bal_dst", 32'(outdst), 32'h8000);
    cyc(beq, 0, 0, 0, 1, 16'h0, 1);
    lit("beq_retire_haz", 32'(haz_seen), 32'd1);
    run(beq);
    lit("beq_issue_bub", 32'(outbubble), 32'd0);
    ret(16'h8000, 0);
    ret(16'h8000, 0);

    // Saturation of r5
    for (int i = 0; i < 3; i++) begin
      run(mov5);
      lit("sat_fill_haz", 32'(haz_seen), 32'd0);
    end
    run(mov5);
    lit("sat_full_haz", 32'(haz_seen), 32'd1);
    cyc(mov5, 0, 0, 0, 1, 16'h0020, 0);
    run(mov5);
    lit("sat_issue_bub", 32'(outbubble), 32'd0);
    for (int i = 0; i < 3; i++) ret(16'h0020, 0);

    // Load-multiple with writeback
    run(ldm);
    lit("ldm_dst", 32'(outdst), 32'h8007);
    run(add312);
    lit("ldm_dep_haz", 32'(haz_seen), 32'd1);
    cyc(add312, 0, 0, 0, 1, 16'h0002, 0);
    cyc(add312, 0, 0, 0, 1, 16'h0004, 0);
    lit("ldm_dep_haz_r2", 32'(haz_seen), 32'd1);
    run(add312);
    lit("ldm_dep_issue", 32'(outbubble), 32'd0);
    ret(16'h8001, 0);
    ret(16'h0008, 0);

    // Stall freezes outputs and counters
    run(mov7);
    cyc(mov6, 0, 1, 0, 0, 16'h0, 0);
    lit("stall_bub", 32'(outbubble), 32'd0);
    lit("stall_dst", 32'(outdst), 32'h0080);
    lit("stall_insn", outinsn, 32'hE3A07001);
    run(add06);
    lit("stall_nocount_haz", 32'(haz_seen), 32'd0);
    ret(16'h0081, 0);

    // Flush drops the input without counting it
    cyc(mov8, 0, 0, 1, 0, 16'h0, 0);
    lit("flush_bub", 32'(outbubble), 32'd1);
    run(add98);
    lit("flush_nocount_haz", 32'(haz_seen), 32'd0);
    lit("flush_next_dst", 32'(outdst), 32'h0200);
    ret(16'h0200, 0);

    // Reset in the middle of a hazard
    run(mov1);
    run(add312);
    lit("rstmid_haz", 32'(haz_seen), 32'd1);
    rst = 1'b1; cyc(add312, 0, 0, 0, 0, 16'h0, 0); rst = 1'b0;
    lit("rstmid_bub", 32'(outbubble), 32'd1);
    run(add312);
    lit("rstmid_issue_haz", 32'(haz_seen), 32'd0);
    lit("rstmid_issue_dst", 32'(outdst), 32'h0008);
    ret(16'h0008, 0);

    // Serializing coprocessor op
    run(mov7);
    run(mcr);
    lit("ser_haz", 32'(haz_seen), 32'd1);
    cyc(mcr, 0, 0, 0, 1, 16'h0080, 0);
    lit("ser_retire_haz", 32'(haz_seen), 32'd1);
    run(mcr);
    lit("ser_issue_bub", 32'(outbubble), 32'd0);
    lit("ser_issue_dst", 32'(outdst), 32'h0000);

    // Randomized traffic
    rst = 1'b1; cyc('0, 1, 0, 0, 0, 16'h0, 0); rst = 1'b0;
    hold = 1'b0;
    cur  = rnd_ins();
    for (int n = 0; n < 4000; n++) begin
      logic        bub = ($urandom_range(0, 5) == 0);
      logic        stl = ($urandom_range(0, 7) == 0);
      logic        fl  = ($urandom_range(0, 11) == 0);
      logic        rv  = 1'b0, rc = 1'b0;
      logic [15:0] rr  = '0;
      if (!hold) cur = rnd_ins();
      if (q.size() > 0 && $urandom_range(0, 1) == 1) begin
        int idx = $urandom_range(0, q.size() - 1);
        rv = 1'b1; rr = q[idx].d; rc = q[idx].c;
        q.delete(idx);
      end
      rst = ($urandom_range(0, 499) == 0);
      cyc(cur, bub, stl, fl, rv, rr, rc);
      hold = haz_seen;
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/issue_scoreboard.md
Name: issue_scoreboard

Overview:
- Hazard controller for the Issue stage of the ARM7-style pipeline.
- Sits between decode and execute and replaces the plain issue register.
- Decodes each instruction's source and destination registers and tracks outstanding writebacks in a per-register scoreboard.
- Holds an instruction back, inserting bubbles, until its operands and flags are settled.

Parameters:
- CNT_W, 2, width of each per-register outstanding-write counter; max outstanding writes = 2^CNT_W-1.
- SERIALIZE_COP, 1, when 1, coprocessor/SWI/undefined instructions wait for a fully empty scoreboard.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- stall  in  1  downstream hold; all stage state frozen.
- flush  in  1  discard the current input instruction.
- inbubble  in  1  input slot empty.
- insn  in  32  instruction word.
- inpc  in  32  instruction address.
- retire_valid  in  1  one issued instruction has retired or been cancelled.
- retire_regs  in  16  destination mask being released (r0..r15).
- retire_cpsr  in  1  CPSR write being released.
- outbubble  out  1  output slot empty.
- outpc  out  32  issued pc.
- outinsn  out  32  issued instruction.
- outdst  out  16  destination mask of the issued instruction.
- outcpsr  out  1  issued instruction writes CPSR.
- hazard  out  1  combinational; current input is blocked; upstream must hold insn/inpc.

Behaviour:
- Reset:
  - outbubble=1; outpc, outinsn and outdst = 0; outcpsr=0.
  - All counters and the CPSR counter = 0.
  - Reset overrides stall, flush and retire in the same cycle.
- Decode, combinational from insn:
  - Multiply is matched before ALU.
  - src: 16-bit source mask; r15 is excluded because PC reads never hazard.
  - dst: destination mask.
  - rdflags: set when cond != 1110.
  - wrflags: S bit of ALU/multiply instructions.
- Per-class decode rules:
  - ALU: src Rn unless MOV/MVN; Rm if I=0; Rs if I=0 and bit4=1. dst Rd unless TST/TEQ/CMP/CMN.
  - Multiply: src Rm, Rs, plus Rn if A=1. dst Rd[19:16].
  - Multiply long: src Rm, Rs, plus [19:16] and [15:12] if A=1. dst [19:16] and [15:12].
  - Swap: src Rn, Rm. dst Rd.
  - BX: src Rm. dst r15.
  - Single/halfword transfer: src Rn; Rm if register offset; Rd if store. dst Rd if load; Rn if W=1 or P=0.
  - Block transfer: src Rn, plus reglist if store. dst reglist if load; Rn if W=1.
  - Branch: dst r15; BL also dst r14.
  - Coprocessor/SWI/undefined: no register masks; serializing when SERIALIZE_COP=1.
- hazard is asserted when !inbubble and !flush and any of the following holds:
  - any src reg has a nonzero counter;
  - rdflags and the CPSR counter is nonzero;
  - any dst reg, or the CPSR when wrflags, has a counter at its maximum;
  - the instruction is serializing and any counter is nonzero.
- Per cycle, with stall=0:
  - Issue = !inbubble & !flush & !hazard.
  - On issue: outbubble<=0; outpc/outinsn/outdst/outcpsr load from the input; counters for dst bits and CPSR (if wrflags) +1.
  - Otherwise outbubble<=1 and outdst/outcpsr<=0.
- stall=1:
  - Outputs hold.
  - No counter increments.
- Retire:
  - retire is applied regardless of stall.
  - Each set bit of retire_regs, and retire_cpsr, decrements its counter by 1.
  - If the same register is issued and retired in one cycle, its counter is unchanged.
  - Retiring a zero counter is a protocol error: assertion fires and the counter stays 0.
- Flush:
  - The current input is dropped.
  - Already-issued instructions remain in the scoreboard; downstream must retire or cancel each one with its outdst/outcpsr.
- Latency: 1 cycle from an unblocked input to issued output.
- A hazard cleared by retire in cycle N issues at the clock edge ending cycle N+1; no bypass.

Decomposition:
- Package arm_isa_pkg holds:
  - instruction class enum;
  - opcode constants (MOV, MVN, TST, TEQ, CMP, CMN);
  - cond AL constant;
  - field bit positions.
- Sub-module arm_reg_decode (combinational): insn -> src, dst, rdflags, wrflags, serialize.
- The counter array and issue register stay in issue_scoreboard.

Test Plan:
- RAW stall:
  - Stimulus: issue ADD r1,r2,r3 (E0821003), then SUB r4,r1,#1 with no retire.
  - Required: hazard=1 and outbubble=1 every cycle; after retire_regs=0x0002, SUB issues on the second edge with outdst=0x0010.
- Flags:
  - Stimulus: issue CMP r0,#0 (E3500000), which gives outcpsr=1, outdst=0; then BEQ (0A000004).
  - Required: BEQ blocked until retire_cpsr; BAL (EA000004) behind CMP issues immediately.
- Saturation:
  - Stimulus: CNT_W=2; three MOV r5 issued without retire; fourth MOV r5 presented.
  - Required: fourth MOV has hazard=1; one retire of 0x0020 lets it issue.
- LDM load:
  - Stimulus: LDMIA r0!,{r1,r2,r15} (E8B08006).
  - Required: outdst=0x8007; a following ADD r3,r1,r2 blocks until both r1 and r2 have retired.
- Stall/flush/reset:
  - Stimulus: stall=1 while an unblocked instruction is presented.
  - Required: outputs frozen and no counter change.
  - Stimulus: flush=1 with an unblocked instruction presented.
  - Required: outbubble=1 and counters unchanged.
  - Stimulus: rst mid-hazard.
  - Required: all counters 0, outbubble=1, and the next instruction issues.
- Serialize: an MCR behind an outstanding r7 write is held until the scoreboard is empty, then issues with outdst=0.
